// File: rtl/settings_pkg.sv
// Shared constants for the 7-bit-address / 32-bit-data serial settings bus
// and a helper that sizes register-index ports.
package settings_pkg;

  localparam int SETTINGS_ADDR_W = 7;
  localparam int SETTINGS_DATA_W = 32;

  // Index ports stay at least one bit wide so a single-register bank still has a legal port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/setting_reg_cell.sv
// One settings register: shadow copy, live copy and a one-cycle changed pulse.
// Bus-originated live loads (commit or direct write) take priority over the override.
module setting_reg_cell #(
  parameter int              WIDTH     = 32,
  parameter bit              SHADOWED  = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_bus_we,
  input  logic [WIDTH-1:0] i_bus_data,
  input  logic             i_commit,
  input  logic             i_ovr_we,
  input  logic [WIDTH-1:0] i_ovr_data,
  output logic [WIDTH-1:0] o_live,
  output logic [WIDTH-1:0] o_shadow,
  output logic             o_changed
);

  logic [WIDTH-1:0] r_live;
  logic [WIDTH-1:0] r_shadow;
  logic             r_changed;
  logic             w_bus_live;
  logic [WIDTH-1:0] w_bus_live_data;

  assign w_bus_live      = SHADOWED ? i_commit : i_bus_we;
  assign w_bus_live_data = SHADOWED ? r_shadow : i_bus_data;

  // NOTE: non-blocking updates mean a commit copies the shadow as it was before this edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_live    <= RESET_VAL;
      r_shadow  <= RESET_VAL;
      r_changed <= 1'b1;
    end else begin
      if (i_bus_we) begin
        r_shadow <= i_bus_data;
      end
      if (w_bus_live) begin
        r_live    <= w_bus_live_data;
        r_changed <= 1'b1;
      end else if (i_ovr_we) begin
        r_live    <= i_ovr_data;
        r_changed <= 1'b1;
      end else begin
        r_changed <= 1'b0;
      end
    end
  end

  assign o_live    = r_live;
  assign o_shadow  = r_shadow;
  assign o_changed = r_changed;

endmodule

// File: rtl/setting_reg_bank.sv
// Bank of settings registers on the serial settings bus with optional shadow
// stage for atomic multi-register commit, local override and registered readback.
module setting_reg_bank
  import settings_pkg::*;
#(
  parameter int                         NUM_REGS    = 4,
  parameter int                         WIDTH       = 32,
  parameter int                         BASE_ADDR   = 0,
  parameter int                         COMMIT_ADDR = 127,
  parameter bit                         SHADOWED    = 1'b1,
  parameter logic [SETTINGS_DATA_W-1:0] RESET_VAL   = '0,
  localparam int                        SEL_W       = idx_width(NUM_REGS)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       strobe,
  input  logic [SETTINGS_ADDR_W-1:0] addr,
  input  logic [SETTINGS_DATA_W-1:0] in,
  input  logic                       ovr_strobe,
  input  logic [SEL_W-1:0]           ovr_sel,
  input  logic [WIDTH-1:0]           ovr_in,
  output logic [NUM_REGS*WIDTH-1:0]  out,
  output logic [NUM_REGS-1:0]        changed,
  output logic                       pending,
  input  logic [SEL_W-1:0]           rd_sel,
  input  logic                       rd_shadow,
  output logic [WIDTH-1:0]           rd_data
);

  if (NUM_REGS < 1 || NUM_REGS > 32) begin : g_bad_num_regs
    $error("setting_reg_bank: NUM_REGS must be 1..32");
  end
  if (WIDTH < 1 || WIDTH > SETTINGS_DATA_W) begin : g_bad_width
    $error("setting_reg_bank: WIDTH must be 1..32");
  end
  if (BASE_ADDR < 0 || BASE_ADDR + NUM_REGS > (1 << SETTINGS_ADDR_W)) begin : g_bad_base
    $error("setting_reg_bank: register window exceeds bus address space");
  end
  if (COMMIT_ADDR >= BASE_ADDR && COMMIT_ADDR < BASE_ADDR + NUM_REGS) begin : g_overlap
    $error("setting_reg_bank: COMMIT_ADDR overlaps the register window");
  end

  localparam logic [SETTINGS_ADDR_W-1:0] COMMIT_A = SETTINGS_ADDR_W'(COMMIT_ADDR);
  localparam logic [WIDTH-1:0]           RST_V    = RESET_VAL[WIDTH-1:0];

  logic [NUM_REGS-1:0] w_hit;
  logic [NUM_REGS-1:0] w_ovr;
  logic [WIDTH-1:0]    w_live   [NUM_REGS];
  logic [WIDTH-1:0]    w_shadow [NUM_REGS];
  logic [WIDTH-1:0]    w_rd_mux;
  logic                w_commit;
  logic                w_unused_in;
  logic                r_pending;
  logic [WIDTH-1:0]    r_rd_data;

  // Bits of the bus word above WIDTH carry no meaning for this bank.
  assign w_unused_in = ^in;
  assign w_commit    = SHADOWED && strobe && (addr == COMMIT_A);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [SETTINGS_ADDR_W-1:0] REG_A = SETTINGS_ADDR_W'(BASE_ADDR + i);

    assign w_hit[i] = strobe && (addr == REG_A);
    assign w_ovr[i] = ovr_strobe && (ovr_sel == SEL_W'(i));

    setting_reg_cell #(
      .WIDTH     (WIDTH),
      .SHADOWED  (SHADOWED),
      .RESET_VAL (RST_V)
    ) u_cell (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_bus_we   (w_hit[i]),
      .i_bus_data (in[WIDTH-1:0]),
      .i_commit   (w_commit),
      .i_ovr_we   (w_ovr[i]),
      .i_ovr_data (ovr_in),
      .o_live     (w_live[i]),
      .o_shadow   (w_shadow[i]),
      .o_changed  (changed[i])
    );

    assign out[i*WIDTH +: WIDTH] = w_live[i];
  end

  // A direct-write bank never holds uncommitted data, so pending can only ever load 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
    end else if (w_commit) begin
      r_pending <= 1'b0;
    end else if (|w_hit) begin
      r_pending <= SHADOWED;
    end
  end

  // NOTE: default first so an out-of-range select reads 0 and no latch is inferred.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        w_rd_mux = rd_shadow ? w_shadow[i] : w_live[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rd_data <= RST_V;
    end else begin
      r_rd_data <= w_rd_mux;
    end
  end

  assign pending = r_pending;
  assign rd_data = r_rd_data;

endmodule

// File: tb/tb_setting_reg_bank.sv
// Scoreboard bench for setting_reg_bank: a shadowed and a direct-write instance
// driven by directed vectors with hand-computed expectations per clock edge.
module tb_setting_reg_bank;

  typedef struct {
    int          cyc;
    bit          dut_d;
    logic [63:0] out;
    logic [3:0]  chg;
    logic        pend;
    logic [15:0] rd;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_err    = 0;

  logic        clock = 1'b0;
  logic        reset_n, strobe, ovr_strobe, rd_shadow, use_d;
  logic [6:0]  addr;
  logic [31:0] in_data;
  logic [1:0]  ovr_sel, rd_sel;
  logic [15:0] ovr_in;

  logic [63:0] out_s, out_d;
  logic [3:0]  chg_s, chg_d;
  logic        pend_s, pend_d;
  logic [15:0] rd_s, rd_d;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  setting_reg_bank #(
    .NUM_REGS(4), .WIDTH(16), .BASE_ADDR(8), .COMMIT_ADDR(127), .SHADOWED(1'b1), .RESET_VAL('0)
  ) dut_s (
    .clock(clock), .reset_n(reset_n), .strobe(strobe & ~use_d), .addr(addr), .in(in_data),
    .ovr_strobe(ovr_strobe & ~use_d), .ovr_sel(ovr_sel), .ovr_in(ovr_in),
    .out(out_s), .changed(chg_s), .pending(pend_s),
    .rd_sel(rd_sel), .rd_shadow(rd_shadow), .rd_data(rd_s)
  );

  setting_reg_bank #(
    .NUM_REGS(4), .WIDTH(16), .BASE_ADDR(8), .COMMIT_ADDR(127), .SHADOWED(1'b0), .RESET_VAL('0)
  ) dut_d (
    .clock(clock), .reset_n(reset_n), .strobe(strobe & use_d), .addr(addr), .in(in_data),
    .ovr_strobe(ovr_strobe & use_d), .ovr_sel(ovr_sel), .ovr_in(ovr_in),
    .out(out_d), .changed(chg_d), .pending(pend_d),
    .rd_sel(rd_sel), .rd_shadow(rd_shadow), .rd_data(rd_d)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what must be seen after the next rising edge.
  task automatic step(input string name, input logic rst, input logic stb, input logic [6:0] a,
                      input logic [31:0] d, input logic ostb, input logic [1:0] osel,
                      input logic [15:0] oin, input logic [1:0] rsel, input logic rsh,
                      input logic [63:0] e_out, input logic [3:0] e_chg, input logic e_pend,
                      input logic [15:0] e_rd);
    exp_t e;
    @(negedge clock);
    reset_n = rst; strobe = stb; addr = a; in_data = d;
    ovr_strobe = ostb; ovr_sel = osel; ovr_in = oin; rd_sel = rsel; rd_shadow = rsh;
    e.cyc = cyc + 1; e.dut_d = use_d; e.out = e_out; e.chg = e_chg;
    e.pend = e_pend; e.rd = e_rd; e.name = name;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      while (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        check({e.name, ".out"},     e.dut_d ? out_d  : out_s,  e.out);
        check({e.name, ".changed"}, e.dut_d ? {60'd0, chg_d} : {60'd0, chg_s}, {60'd0, e.chg});
        check({e.name, ".pending"}, e.dut_d ? {63'd0, pend_d} : {63'd0, pend_s}, {63'd0, e.pend});
        check({e.name, ".rd_data"}, e.dut_d ? {48'd0, rd_d} : {48'd0, rd_s}, {48'd0, e.rd});
      end
    end
  end

  initial begin
    reset_n = 1'b0; strobe = 1'b0; addr = '0; in_data = '0; ovr_strobe = 1'b0;
    ovr_sel = '0; ovr_in = '0; rd_sel = '0; rd_shadow = 1'b0; use_d = 1'b0;

    //    name     rst stb addr  data          ostb sel oin       rs sh  out                    chg      p  rd
    step("rst1",   0,  0,  7'd0, 32'h0,        0,   0,  16'h0,    0, 0,  64'h0,                 4'b1111, 0, 16'h0);
    step("rst2",   0,  0,  7'd0, 32'h0,        0,   0,  16'h0,    0, 0,  64'h0,                 4'b1111, 0, 16'h0);
    step("rst3",   0,  0,  7'd0, 32'h0,        0,   0,  16'h0,    0, 0,  64'h0,                 4'b1111, 0, 16'h0);
    step("idle",   1,  0,  7'd0, 32'h0,        0,   0,  16'h0,    0, 0,  64'h0,                 4'b0000, 0, 16'h0);

    step("sh_w8",  1,  1,  7'd8, 32'hFFFF_AAAA,0,   0,  16'h0,    1, 1,  64'h0,                 4'b0000, 1, 16'h0);
    step("sh_w9",  1,  1,  7'd9, 32'h0000_5555,0,   0,  16'h0,    0, 1,  64'h0,                 4'b0000, 1, 16'hAAAA);
    step("sh_w20", 1,  1,  7'd20,32'h0000_1111,0,   0,  16'h0,    1, 1,  64'h0,                 4'b0000, 1, 16'h5555);
    step("commit", 1,  1,  7'd127,32'h0000_DEAD,0,  0,  16'h0,    0, 0,  64'h0000_0000_5555_AAAA, 4'b1111, 0, 16'h0);
    step("post_c", 1,  0,  7'd0, 32'h0,        0,   0,  16'h0,    1, 0,  64'h0000_0000_5555_AAAA, 4'b0000, 0, 16'h5555);

    step("c3_w8",  1,  1,  7'd8, 32'h0000_0101,0,   0,  16'h0,    0, 0,  64'h0000_0000_5555_AAAA, 4'b0000, 1, 16'hAAAA);
    step("c3_w10", 1,  1,  7'd10,32'h0000_0303,0,   0,  16'h0,    2, 1,  64'h0000_0000_5555_AAAA, 4'b0000, 1, 16'h0);
    step("col0",   1,  1,  7'd127,32'h0,       1,   0,  16'h1234, 2, 1,  64'h0000_0303_5555_0101, 4'b1111, 0, 16'h0303);
    step("col2",   1,  1,  7'd127,32'h0,       1,   2,  16'h9999, 2, 0,  64'h0000_0303_5555_0101, 4'b1111, 0, 16'h0303);
    step("col_end",1,  0,  7'd0, 32'h0,        0,   0,  16'h0,    2, 0,  64'h0000_0303_5555_0101, 4'b0000, 0, 16'h0303);

    step("o_w11",  1,  1,  7'd11,32'h0000_3333,0,   0,  16'h0,    3, 0,  64'h0000_0303_5555_0101, 4'b0000, 1, 16'h0);
    step("ovr3",   1,  0,  7'd0, 32'h0,        1,   3,  16'hBEEF, 3, 1,  64'hBEEF_0303_5555_0101, 4'b1000, 1, 16'h3333);
    step("ovr3_rd",1,  0,  7'd0, 32'h0,        0,   0,  16'h0,    3, 1,  64'hBEEF_0303_5555_0101, 4'b0000, 1, 16'h3333);
    step("ovr1_w8",1,  1,  7'd8, 32'h0000_0808,1,   1,  16'h1111, 0, 1,  64'hBEEF_0303_1111_0101, 4'b0010, 1, 16'h0101);

    step("mid_rst",0,  0,  7'd0, 32'h0,        0,   0,  16'h0,    0, 1,  64'h0,                 4'b1111, 0, 16'h0);
    step("mr_rd3", 1,  0,  7'd0, 32'h0,        0,   0,  16'h0,    3, 1,  64'h0,                 4'b0000, 0, 16'h0);
    step("mr_cmt", 1,  1,  7'd127,32'h0,       0,   0,  16'h0,    0, 0,  64'h0,                 4'b1111, 0, 16'h0);
    step("mr_end", 1,  0,  7'd0, 32'h0,        0,   0,  16'h0,    0, 0,  64'h0,                 4'b0000, 0, 16'h0);

    use_d = 1'b1;
    step("d_w10",  1,  1,  7'd10,32'h0000_0077,0,   0,  16'h0,    2, 0,  64'h0000_0077_0000_0000, 4'b0100, 0, 16'h0);
    step("d_w127", 1,  1,  7'd127,32'h0000_FFFF,0,  0,  16'h0,    2, 1,  64'h0000_0077_0000_0000, 4'b0000, 0, 16'h0077);
    step("d_w12",  1,  1,  7'd12,32'h0000_4444,0,   0,  16'h0,    2, 0,  64'h0000_0077_0000_0000, 4'b0000, 0, 16'h0077);
    step("d_col0", 1,  1,  7'd8, 32'h0000_0A0A,1,   0,  16'h1234, 0, 0,  64'h0000_0077_0000_0A0A, 4'b0001, 0, 16'h0);
    step("d_ovr3", 1,  0,  7'd0, 32'h0,        1,   3,  16'hBEEF, 0, 1,  64'hBEEF_0077_0000_0A0A, 4'b1000, 0, 16'h0A0A);
    step("d_rd3",  1,  0,  7'd0, 32'h0,        0,   0,  16'h0,    3, 1,  64'hBEEF_0077_0000_0A0A, 4'b0000, 0, 16'h0);

    @(negedge clock);
    strobe = 1'b0; ovr_strobe = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d unchecked expectations, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
